// File: rtl/usb_typec_auth_responder.sv
// USB Type-C Authentication responder (device side): latches a request from the
// PD or DEBUG transport, acknowledges it, decodes the header and returns a response.
// Latency: ready sampled at edge N -> Ack_in after N+1 -> auth_msg_ready after N+2.
// Backpressure: ready inputs are only honoured in IDLE; the sender holds ready until Ack_in.
//
// Ports:
//   clk, reset (sync, active-low)
//   auth_msg_in[MSG_LEN]       request {payload, Param2, Param1, MessageType, ProtocolVersion}
//   PD_in_ready, DEBUG_in_ready request valid per channel (PD has priority)
//   Ack_in                     one-cycle acknowledge that the request was latched
//   pending_auth_request[8]    MessageType of the outstanding request, 0x00 when none
//   auth_msg_ready             one-cycle strobe, auth_msg_out valid
//   auth_msg_out[MSG_LEN]      response, same layout as the request
module usb_typec_auth_responder #(
    parameter int          MSG_LEN   = 64,
    parameter logic [7:0]  SLOT_MASK = 8'h01,
    parameter logic [31:0] DIGEST    = 32'hD1D1_0001,
    parameter logic [31:0] CERT_DATA = 32'hCE47_0001,
    parameter logic [31:0] KEY       = 32'h5A5A_A5A5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [MSG_LEN-1:0] auth_msg_in,
    input  logic               PD_in_ready,
    input  logic               DEBUG_in_ready,
    output logic               Ack_in,
    output logic [7:0]         pending_auth_request,
    output logic               auth_msg_ready,
    output logic [MSG_LEN-1:0] auth_msg_out
);

    localparam logic [7:0] VER_1          = 8'h01;
    localparam logic [7:0] MT_DIGESTS     = 8'h01;
    localparam logic [7:0] MT_CERTIFICATE = 8'h02;
    localparam logic [7:0] MT_CHAL_AUTH   = 8'h03;
    localparam logic [7:0] MT_ERROR       = 8'h7F;
    localparam logic [7:0] MT_GET_DIGESTS = 8'h81;
    localparam logic [7:0] MT_GET_CERT    = 8'h82;
    localparam logic [7:0] MT_CHALLENGE   = 8'h83;
    localparam logic [7:0] ERR_INVALID    = 8'h01;
    localparam logic [7:0] ERR_UNSUP_PROT = 8'h02;

    // Place a 32-bit constant in the payload field (bits MSG_LEN-1:32),
    // zero-extending or truncating it to the payload width. Building the
    // full-width word this way stays legal even when there is no payload.
    function automatic logic [MSG_LEN-1:0] place_payload(input logic [31:0] val);
        logic [MSG_LEN+31:0] ext;
        logic [MSG_LEN+31:0] shifted;
        ext     = {{MSG_LEN{1'b0}}, val};
        shifted = {ext[MSG_LEN-1:0], 32'h0};
        return shifted[MSG_LEN-1:0];
    endfunction

    localparam logic [MSG_LEN-1:0] DIGEST_W = place_payload(DIGEST);
    localparam logic [MSG_LEN-1:0] CERT_W   = place_payload(CERT_DATA);
    localparam logic [MSG_LEN-1:0] KEY_W    = place_payload(KEY);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DECODE  = 2'd1,
        RESPOND = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [MSG_LEN-1:0] msg_q, msg_d;
    logic [MSG_LEN-1:0] resp_q, resp_d;
    logic [MSG_LEN-1:0] out_q, out_d;
    logic               ack_q, ack_d;
    logic               rdy_q, rdy_d;
    logic [7:0]         pend_q, pend_d;

    logic       req_vld;
    logic [7:0] req_ver;
    logic [7:0] req_type;
    logic [7:0] req_slot;
    logic       slot_ok;

    // Both channels share the request bus, so PD priority only means that
    // simultaneous readies produce a single acceptance of that bus value.
    assign req_vld  = PD_in_ready | DEBUG_in_ready;
    assign req_ver  = msg_q[7:0];
    assign req_type = msg_q[15:8];
    assign req_slot = msg_q[23:16];
    assign slot_ok  = (req_slot < 8'd8) && SLOT_MASK[req_slot[2:0]];

    // State register and all output/datapath flops.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            msg_q   <= '0;
            resp_q  <= '0;
            out_q   <= '0;
            ack_q   <= 1'b0;
            rdy_q   <= 1'b0;
            pend_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            msg_q   <= msg_d;
            resp_q  <= resp_d;
            out_q   <= out_d;
            ack_q   <= ack_d;
            rdy_q   <= rdy_d;
            pend_q  <= pend_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_vld) state_d = DECODE;
            DECODE:  state_d = RESPOND;
            RESPOND: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath logic.
    always_comb begin
        msg_d  = msg_q;
        resp_d = resp_q;
        out_d  = out_q;
        ack_d  = 1'b0;
        rdy_d  = 1'b0;
        pend_d = pend_q;
        case (state_q)
            IDLE: begin
                pend_d = 8'h00;
                if (req_vld) msg_d = auth_msg_in;
            end
            DECODE: begin
                ack_d  = 1'b1;
                pend_d = req_type;
                resp_d = '0;
                if (req_ver != VER_1) begin
                    resp_d[31:8] = {8'h00, ERR_UNSUP_PROT, MT_ERROR};
                end else begin
                    case (req_type)
                        MT_GET_DIGESTS: begin
                            resp_d       = DIGEST_W;
                            resp_d[31:8] = {SLOT_MASK, 8'h00, MT_DIGESTS};
                        end
                        MT_GET_CERT: begin
                            if (slot_ok) begin
                                resp_d       = CERT_W;
                                resp_d[31:8] = {8'h00, req_slot, MT_CERTIFICATE};
                            end else begin
                                resp_d[31:8] = {8'h00, ERR_INVALID, MT_ERROR};
                            end
                        end
                        MT_CHALLENGE: begin
                            if (slot_ok) begin
                                // Header bits are overwritten below; only the payload XOR matters.
                                resp_d       = msg_q ^ KEY_W;
                                resp_d[31:8] = {SLOT_MASK, req_slot, MT_CHAL_AUTH};
                            end else begin
                                resp_d[31:8] = {8'h00, ERR_INVALID, MT_ERROR};
                            end
                        end
                        default: resp_d[31:8] = {8'h00, ERR_INVALID, MT_ERROR};
                    endcase
                end
                resp_d[7:0] = VER_1;
            end
            RESPOND: begin
                rdy_d = 1'b1;
                out_d = resp_q;
            end
            default: ;
        endcase
    end

    assign Ack_in               = ack_q;
    assign auth_msg_ready       = rdy_q;
    assign pending_auth_request = pend_q;
    assign auth_msg_out         = out_q;

endmodule

// File: tb/tb_usb_typec_auth_responder.sv
module tb_usb_typec_auth_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] auth_msg_in;
    logic        PD_in_ready;
    logic        DEBUG_in_ready;
    logic        Ack_in;
    logic [7:0]  pending_auth_request;
    logic        auth_msg_ready;
    logic [63:0] auth_msg_out;

    int compared   = 0;
    int mismatched = 0;
    int ack_cnt    = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    usb_typec_auth_responder dut (
        .clk                  (clk),
        .reset                (reset),
        .auth_msg_in          (auth_msg_in),
        .PD_in_ready          (PD_in_ready),
        .DEBUG_in_ready       (DEBUG_in_ready),
        .Ack_in               (Ack_in),
        .pending_auth_request (pending_auth_request),
        .auth_msg_ready       (auth_msg_ready),
        .auth_msg_out         (auth_msg_out)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: counts acknowledges and scores every response against the queue.
    always @(negedge clk) begin
        if (Ack_in === 1'b1) ack_cnt++;
        if (auth_msg_ready === 1'b1) begin
            compared++;
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("FAIL resp_unexpected: got %h expected no response", auth_msg_out);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if (auth_msg_out !== e) begin
                    mismatched++;
                    $display("FAIL resp_data: got %h expected %h", auth_msg_out, e);
                end
            end
        end
    end

    // One request/response transaction. 'hold' keeps ready high through the
    // DECODE and RESPOND edges to show it is ignored outside IDLE.
    task automatic send(input string name, input logic pd, input logic dbg,
                        input logic [63:0] msg, input logic [63:0] exp, input bit hold);
        int k;
        int acks0;
        acks0 = ack_cnt;
        exp_q.push_back(exp);
        @(negedge clk);
        auth_msg_in    = msg;
        PD_in_ready    = pd;
        DEBUG_in_ready = dbg;
        k = 0;
        while (Ack_in !== 1'b1 && k < 8) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= 8) $display("FAIL %s ack_timeout: got no ack expected ack", name);
        check({name, "_ack_lat"}, 64'(k), 64'd2);
        check({name, "_pend"}, 64'(pending_auth_request), 64'(msg[15:8]));
        if (!hold) begin
            PD_in_ready    = 1'b0;
            DEBUG_in_ready = 1'b0;
        end
        @(posedge clk); #1;
        check({name, "_rdy_strobe"}, 64'(auth_msg_ready), 64'd1);
        PD_in_ready    = 1'b0;
        DEBUG_in_ready = 1'b0;
        @(posedge clk); #1;
        check({name, "_pend_clr"}, 64'(pending_auth_request), 64'd0);
        check({name, "_rdy_off"}, 64'(auth_msg_ready), 64'd0);
        @(negedge clk);
        check({name, "_ack_count"}, 64'(ack_cnt - acks0), 64'd1);
    endtask

    initial begin
        reset          = 1'b0;
        auth_msg_in    = '0;
        PD_in_ready    = 1'b0;
        DEBUG_in_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ack", 64'(Ack_in), 64'd0);
        check("rst_rdy", 64'(auth_msg_ready), 64'd0);
        check("rst_pend", 64'(pending_auth_request), 64'd0);
        check("rst_out", auth_msg_out, 64'd0);
        check("rst_no_ack", 64'(ack_cnt), 64'd0);

        // GET_DIGESTS over PD
        send("digests", 1, 0, {32'h0, 8'h00, 8'h00, 8'h81, 8'h01},
             {32'hD1D1_0001, 8'h01, 8'h00, 8'h01, 8'h01}, 0);
        // CHALLENGE slot 0 over DEBUG: 12345678 ^ 5A5AA5A5 = 486EF3DD
        send("challenge", 0, 1, {32'h1234_5678, 8'h00, 8'h00, 8'h83, 8'h01},
             {32'h486E_F3DD, 8'h01, 8'h00, 8'h03, 8'h01}, 0);
        // CHALLENGE on unpopulated slot 1
        send("chal_bad_slot", 1, 0, {32'hFFFF_FFFF, 8'h00, 8'h01, 8'h83, 8'h01},
             {32'h0, 8'h00, 8'h01, 8'h7F, 8'h01}, 0);
        // GET_CERTIFICATE slot 0 (populated)
        send("cert_ok", 1, 0, {32'h0, 8'h00, 8'h00, 8'h82, 8'h01},
             {32'hCE47_0001, 8'h00, 8'h00, 8'h02, 8'h01}, 0);
        // GET_CERTIFICATE slot 3 (unpopulated)
        send("cert_slot3", 1, 0, {32'h0, 8'h00, 8'h03, 8'h82, 8'h01},
             {32'h0, 8'h00, 8'h01, 8'h7F, 8'h01}, 0);
        // GET_CERTIFICATE slot 9 (out of range)
        send("cert_slot9", 0, 1, {32'h0, 8'h00, 8'h09, 8'h82, 8'h01},
             {32'h0, 8'h00, 8'h01, 8'h7F, 8'h01}, 0);
        // Unknown MessageType
        send("type_90", 1, 0, {32'hAAAA_5555, 8'h12, 8'h34, 8'h90, 8'h01},
             {32'h0, 8'h00, 8'h01, 8'h7F, 8'h01}, 0);
        // Bad protocol version
        send("version_02", 1, 0, {32'h0, 8'h00, 8'h00, 8'h81, 8'h02},
             {32'h0, 8'h00, 8'h02, 8'h7F, 8'h01}, 0);
        // PD and DEBUG together: one ack only
        send("both_rdy", 1, 1, {32'h0, 8'h00, 8'h00, 8'h81, 8'h01},
             {32'hD1D1_0001, 8'h01, 8'h00, 8'h01, 8'h01}, 0);
        // Ready held during DECODE/RESPOND: still one ack
        send("hold_rdy", 1, 0, {32'h0, 8'h00, 8'h00, 8'h82, 8'h01},
             {32'hCE47_0001, 8'h00, 8'h00, 8'h02, 8'h01}, 1);

        // Reset in the DECODE cycle: no response, outputs cleared.
        begin
            int acks0;
            acks0 = ack_cnt;
            @(negedge clk);
            auth_msg_in = {32'h0, 8'h00, 8'h00, 8'h81, 8'h01};
            PD_in_ready = 1'b1;
            @(posedge clk); #1;
            PD_in_ready = 1'b0;
            reset       = 1'b0;
            @(posedge clk); #1;
            @(posedge clk); #1;
            reset = 1'b1;
            check("abort_ack", 64'(Ack_in), 64'd0);
            check("abort_pend", 64'(pending_auth_request), 64'd0);
            check("abort_out", auth_msg_out, 64'd0);
            check("abort_rdy", 64'(auth_msg_ready), 64'd0);
            repeat (4) @(posedge clk);
            @(negedge clk);
            check("abort_no_ack", 64'(ack_cnt - acks0), 64'd0);
        end

        // Recovery after abort
        send("recover", 0, 1, {32'h0000_0000, 8'h00, 8'h00, 8'h83, 8'h01},
             {32'h5A5A_A5A5, 8'h01, 8'h00, 8'h03, 8'h01}, 0);

        repeat (4) @(posedge clk);
        @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/usb_typec_auth_responder.md
Name: usb_typec_auth_responder

Overview:
- USB Type-C Authentication responder (device side).
- Accepts request messages delivered by the PD or DEBUG transport driver, acknowledges them, decodes the authentication header, and returns a response on auth_msg_out with a one-cycle ready strobe.
- Sits between the PD/DEBUG driver model and the authentication engine; responses come from parameterised constant data (digest, certificate, signing key).

Parameters:
- MSG_LEN, 64, message width in bits; must be >= 32; payload = bits MSG_LEN-1:32.
- SLOT_MASK, 8'h01, populated certificate slots, one bit per slot 0..7.
- DIGEST, 32'hD1D1_0001, digest payload returned in DIGESTS; zero-extended/truncated to MSG_LEN-32.
- CERT_DATA, 32'hCE47_0001, certificate payload returned in CERTIFICATE; same sizing.
- KEY, 32'h5A5A_A5A5, XOR key used to form the CHALLENGE_AUTH signature.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- auth_msg_in  in  MSG_LEN  request: [7:0] ProtocolVersion, [15:8] MessageType, [23:16] Param1, [31:24] Param2, [MSG_LEN-1:32] payload.
- PD_in_ready  in  1  request valid on the PD channel.
- DEBUG_in_ready  in  1  request valid on the DEBUG channel.
- Ack_in  out  1  one-cycle acknowledge: request latched.
- pending_auth_request  out  8  MessageType of the outstanding request; 0x00 when none.
- auth_msg_ready  out  1  one-cycle strobe: auth_msg_out valid.
- auth_msg_out  out  MSG_LEN  response, same field layout as auth_msg_in.

Behaviour:
- Reset (reset==0 at a clock edge):
  - state IDLE.
  - Ack_in, auth_msg_ready, pending_auth_request, auth_msg_out all 0.
  - Reset mid-operation aborts the transaction; no response is emitted.
- States: IDLE -> DECODE -> RESPOND -> IDLE.
- IDLE:
  - If PD_in_ready or DEBUG_in_ready is 1, latch auth_msg_in (PD wins if both are high; the request is accepted only once).
  - Next cycle: Ack_in=1 for one cycle, pending_auth_request = latched MessageType, go to DECODE.
- DECODE (one cycle), builds the response:
  - Version != 0x01 -> ERROR (0x7F), Param1=0x02 (UnsupportedProtocol), Param2=0, payload 0.
  - 0x81 GET_DIGESTS -> DIGESTS (0x01), Param1=0, Param2=SLOT_MASK, payload=DIGEST.
  - 0x82 GET_CERTIFICATE, slot=Param1:
    - slot<8 and SLOT_MASK[slot]=1 -> CERTIFICATE (0x02), Param1=slot, Param2=0, payload=CERT_DATA.
    - otherwise -> ERROR, Param1=0x01 (InvalidRequest).
  - 0x83 CHALLENGE, same slot check:
    - valid slot -> CHALLENGE_AUTH (0x03), Param1=slot, Param2=SLOT_MASK, payload = request payload XOR KEY.
    - invalid slot -> ERROR InvalidRequest.
  - Any other MessageType -> ERROR InvalidRequest.
  - Every response has ProtocolVersion byte 0x01.
- RESPOND:
  - auth_msg_out updated and auth_msg_ready=1 for exactly one cycle.
  - Next cycle: pending_auth_request=0x00, state IDLE.
- Latency:
  - Ready sampled at edge N; Ack_in high after N+1; auth_msg_ready high after N+2; pending cleared after N+3.
  - A new request is accepted at the earliest at edge N+3.
- auth_msg_out holds its last value until the next response; it is never cleared except by reset.
- Ready inputs asserted while not IDLE are ignored; no ack is given. The sender holds ready until it sees Ack_in.
- Ready still high in IDLE after a completed transaction is treated as a new request.
- The DEBUG channel is serviced identically to PD.

Test Plan:
- Reset low 2 cycles, then high -> all outputs 0, pending_auth_request=0x00; no ack while ready inputs are low.
- PD_in_ready pulse with {32'h0, 8'h00,8'h00,8'h81,8'h01} -> Ack_in pulse at +1; pending=0x81; at +2 auth_msg_ready=1 and auth_msg_out={32'hD1D10001,8'h01,8'h00,8'h01,8'h01}; pending=0x00 at +3.
- DEBUG_in_ready with CHALLENGE slot 0, payload 32'h1234_5678 -> CHALLENGE_AUTH, payload 32'h486E_F3DD, Param1=0, Param2=0x01.
- GET_CERTIFICATE slot 3 (unpopulated), and separately MessageType 0x90 -> ERROR 0x7F, Param1=0x01 in both cases.
- Version byte 0x02 -> ERROR, Param1=0x02. PD and DEBUG high in the same cycle -> single ack, PD message used. Ready asserted during DECODE -> no extra ack.
- Reset asserted in the DECODE cycle -> no auth_msg_ready pulse; outputs 0 afterwards.
